// File: rtl/rect_draw_engine.sv
// Rectangle rasteriser: fill, outline or clear-screen, clipped to the screen, one pixel per cycle.
// Latency: first pixel the cycle after the start is accepted; oDone one cycle after the last transfer.
// Backpressure: iStall holds the presented pixel (oPlot stays high) until it is transferred.
module rect_draw_engine #(
    parameter int X_SCREEN = 160,
    parameter int Y_SCREEN = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOR_W  = 3
) (
    input  logic               clock,
    input  logic               iResetn,
    input  logic               iStart,
    input  logic [1:0]         iMode,
    input  logic [X_W-1:0]     iX,
    input  logic [Y_W-1:0]     iY,
    input  logic [X_W-1:0]     iW,
    input  logic [Y_W-1:0]     iH,
    input  logic [COLOR_W-1:0] iColour,
    input  logic               iStall,
    output logic [X_W-1:0]     oX,
    output logic [Y_W-1:0]     oY,
    output logic [COLOR_W-1:0] oColour,
    output logic               oPlot,
    output logic               oBusy,
    output logic               oDone
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] M_OUTLINE = 2'b01;
    localparam logic [1:0] M_CLEAR   = 2'b10;

    // Screen limits carried one bit wider than coordinates so no compare can wrap.
    localparam logic [X_W:0] XS = (X_W+1)'(X_SCREEN);
    localparam logic [Y_W:0] YS = (Y_W+1)'(Y_SCREEN);

    logic [1:0]         state;

    // Latched command (box corners as inclusive start/end coordinates).
    logic [X_W-1:0]     x_start;
    logic [Y_W-1:0]     y_start;
    logic [X_W:0]       x_end;
    logic [Y_W:0]       y_end;
    logic               outline;

    // Command as seen at the input, after clear-mode substitution and clipping.
    logic [X_W-1:0]     cmd_x;
    logic [Y_W-1:0]     cmd_y;
    logic [X_W:0]       cmd_w;
    logic [Y_W:0]       cmd_h;
    logic [COLOR_W-1:0] cmd_col;
    logic [X_W:0]       x_room;
    logic [Y_W:0]       y_room;
    logic [X_W:0]       eff_w;
    logic [Y_W:0]       eff_h;

    // Scan position decode.
    logic               at_x_end;
    logic               at_y_end;
    logic               interior_row;

    // Select the command source and clip the box against the screen edges.
    always_comb begin
        cmd_x   = iX;
        cmd_y   = iY;
        cmd_w   = {1'b0, iW};
        cmd_h   = {1'b0, iH};
        cmd_col = iColour;
        if (iMode == M_CLEAR) begin
            cmd_x   = '0;
            cmd_y   = '0;
            cmd_w   = XS;
            cmd_h   = YS;
            cmd_col = '0;
        end
        x_room = XS - {1'b0, cmd_x};
        y_room = YS - {1'b0, cmd_y};
        if ({1'b0, cmd_x} >= XS)
            eff_w = '0;
        else
            eff_w = (cmd_w < x_room) ? cmd_w : x_room;
        if ({1'b0, cmd_y} >= YS)
            eff_h = '0;
        else
            eff_h = (cmd_h < y_room) ? cmd_h : y_room;
    end

    // Where the current pixel sits in the box; interior rows are skipped across in outline mode.
    always_comb begin
        at_x_end     = ({1'b0, oX} == x_end);
        at_y_end     = ({1'b0, oY} == y_end);
        interior_row = (oY != y_start) && !at_y_end;
    end

    // Command latch, raster scan and completion handshake.
    always_ff @(posedge clock) begin
        if (!iResetn) begin
            state   <= S_IDLE;
            x_start <= '0;
            y_start <= '0;
            x_end   <= '0;
            y_end   <= '0;
            outline <= 1'b0;
            oX      <= '0;
            oY      <= '0;
            oColour <= '0;
            oPlot   <= 1'b0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    oDone <= 1'b0;
                    if (iStart) begin
                        x_start <= cmd_x;
                        y_start <= cmd_y;
                        x_end   <= {1'b0, cmd_x} + eff_w - 1'b1;
                        y_end   <= {1'b0, cmd_y} + eff_h - 1'b1;
                        outline <= (iMode == M_OUTLINE);
                        oX      <= cmd_x;
                        oY      <= cmd_y;
                        oColour <= cmd_col;
                        oBusy   <= 1'b1;
                        if (eff_w == '0 || eff_h == '0) begin
                            // Fully clipped box: complete without emitting anything.
                            state <= S_DONE;
                            oPlot <= 1'b0;
                            oDone <= 1'b1;
                        end else begin
                            state <= S_SCAN;
                            oPlot <= 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                    if (!iStall) begin
                        if (at_x_end && at_y_end) begin
                            state <= S_DONE;
                            oPlot <= 1'b0;
                            oDone <= 1'b1;
                        end else if (at_x_end) begin
                            oX <= x_start;
                            oY <= oY + 1'b1;
                        end else if (outline && interior_row) begin
                            oX <= x_end[X_W-1:0];
                        end else begin
                            oX <= oX + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    oDone <= 1'b0;
                    oBusy <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    oPlot <= 1'b0;
                    oDone <= 1'b0;
                    oBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule
